// File: rtl/tt_vpu_slot_alloc.sv
// Round-robin free-slot allocator: tracks busy buffer entries and offers the
// next free slot index at or after the round-robin pointer, wrapping past the end.
module tt_vpu_slot_alloc #(
    parameter int NUM_SLOTS = 32,
    parameter int IDX_WIDTH = $clog2(NUM_SLOTS),
    parameter int CNT_WIDTH = $clog2(NUM_SLOTS + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_alloc_req,
    output logic                 o_alloc_vld,
    output logic [IDX_WIDTH-1:0] o_alloc_idx,
    output logic                 o_alloc_fire,
    input  logic                 i_free_vld,
    input  logic [IDX_WIDTH-1:0] i_free_idx,
    output logic [NUM_SLOTS-1:0] o_busy_vec,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_full,
    output logic                 o_empty
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(NUM_SLOTS);
    localparam logic [IDX_WIDTH:0]   SCAN_LIM = (IDX_WIDTH + 1)'(NUM_SLOTS);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_SLOTS - 1);

    logic [NUM_SLOTS-1:0] busy_q, busy_d;
    logic [NUM_SLOTS-1:0] alloc_mask, free_mask, eff_free;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, offer_idx;
    logic [IDX_WIDTH:0]   scan;
    logic                 found, full, fire, free_ok;

    assign full = (count_q == CNT_FULL);
    assign fire = i_alloc_req & ~full;

    // Scan starts at rr_ptr; one extra bit lets the sum exceed NUM_SLOTS before the wrap.
    always_comb begin
        offer_idx = '0;
        found     = 1'b0;
        scan      = '0;
        for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
            scan = {1'b0, rr_ptr_q} + (IDX_WIDTH + 1)'(k);
            if (scan >= SCAN_LIM) begin
                scan = scan - SCAN_LIM;
            end
            if (!found && !busy_q[scan[IDX_WIDTH-1:0]]) begin
                found     = 1'b1;
                offer_idx = scan[IDX_WIDTH-1:0];
            end
        end
    end

    // Decoding against each legal slot drops out-of-range free indices for free.
    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
            alloc_mask[s] = fire && (offer_idx == IDX_WIDTH'(s));
            free_mask[s]  = i_free_vld && (i_free_idx == IDX_WIDTH'(s));
        end
    end

    assign eff_free = free_mask & busy_q;
    assign free_ok  = |eff_free;
    assign busy_d   = (busy_q & ~eff_free) | alloc_mask;

    always_comb begin
        count_d = count_q;
        if (fire && !free_ok) begin
            count_d = count_q + CNT_WIDTH'(1);
        end else if (!fire && free_ok) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            busy_q   <= '0;
            count_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            if (fire) begin
                rr_ptr_q <= (offer_idx == IDX_LAST) ? '0 : offer_idx + IDX_WIDTH'(1);
            end
        end
    end

    assign o_alloc_vld  = ~full;
    assign o_alloc_idx  = full ? '0 : offer_idx;
    assign o_alloc_fire = fire;
    assign o_busy_vec   = busy_q;
    assign o_count      = count_q;
    assign o_full       = full;
    assign o_empty      = (count_q == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (int'(count_q) == $countones(busy_q))
                else $error("slot_alloc: count %0d disagrees with busy bitmap %b", count_q, busy_q);
            assert (!fire || !busy_q[offer_idx])
                else $error("slot_alloc: granted busy slot %0d", offer_idx);
            assert (o_alloc_vld == ~o_full)
                else $error("slot_alloc: offer valid inconsistent with full flag");
            if (i_free_vld) begin
                assert (free_ok)
                    else $warning("slot_alloc: ignored release of slot %0d (not busy or out of range)", i_free_idx);
            end
        end
    end

endmodule

// File: tb/tb_tt_vpu_slot_alloc.sv
// Directed bench for tt_vpu_slot_alloc: a 4-slot instance driven through a
// scoreboard of expected grants, plus a 3-slot instance for non-power-of-2 wrap.
module tb_tt_vpu_slot_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic       free_vld = 1'b0;
    logic [1:0] free_idx = '0;
    logic       alloc_vld, alloc_fire, full, empty;
    logic [1:0] alloc_idx;
    logic [3:0] busy_vec;
    logic [2:0] count;

    logic       r3_reset = 1'b1;
    logic       r3_req = 1'b0;
    logic       r3_free_vld = 1'b0;
    logic [1:0] r3_free_idx = '0;
    logic       r3_vld, r3_fire, r3_full, r3_empty;
    logic [1:0] r3_idx;
    logic [2:0] r3_busy;
    logic [1:0] r3_count;

    tt_vpu_slot_alloc #(.NUM_SLOTS(4), .IDX_WIDTH(2), .CNT_WIDTH(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_alloc_req(alloc_req),
        .o_alloc_vld(alloc_vld), .o_alloc_idx(alloc_idx), .o_alloc_fire(alloc_fire),
        .i_free_vld(free_vld), .i_free_idx(free_idx),
        .o_busy_vec(busy_vec), .o_count(count), .o_full(full), .o_empty(empty)
    );

    tt_vpu_slot_alloc #(.NUM_SLOTS(3), .IDX_WIDTH(2), .CNT_WIDTH(2)) dut3 (
        .i_clk(clk), .i_reset(r3_reset), .i_alloc_req(r3_req),
        .o_alloc_vld(r3_vld), .o_alloc_idx(r3_idx), .o_alloc_fire(r3_fire),
        .i_free_vld(r3_free_vld), .i_free_idx(r3_free_idx),
        .o_busy_vec(r3_busy), .o_count(r3_count), .o_full(r3_full), .o_empty(r3_empty)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the 4-slot instance; expected grants go through the queue.
    task automatic cyc(input logic req, input logic fv, input logic [1:0] fidx,
                       input logic rst, input logic exp_fire, input int exp_idx);
        @(negedge clk);
        alloc_req = req;
        free_vld  = fv;
        free_idx  = fidx;
        reset     = rst;
        if (exp_fire) exp_q.push_back(exp_idx);
        #1;
        if (!rst) chk("fire", {31'd0, alloc_fire}, {31'd0, exp_fire});
        if (!rst && alloc_fire && exp_q.size() > 0) chk("grant_idx", {30'd0, alloc_idx}, exp_q.pop_front());
        @(posedge clk);
        #1;
        alloc_req = 1'b0;
        free_vld  = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic st(input string tag, input logic [3:0] e_busy, input logic [2:0] e_cnt,
                      input logic e_full, input logic e_empty, input logic e_vld, input logic [1:0] e_idx);
        chk({tag, ".busy"},  {28'd0, busy_vec},  {28'd0, e_busy});
        chk({tag, ".count"}, {29'd0, count},     {29'd0, e_cnt});
        chk({tag, ".full"},  {31'd0, full},      {31'd0, e_full});
        chk({tag, ".empty"}, {31'd0, empty},     {31'd0, e_empty});
        chk({tag, ".vld"},   {31'd0, alloc_vld}, {31'd0, e_vld});
        chk({tag, ".idx"},   {30'd0, alloc_idx}, {30'd0, e_idx});
    endtask

    task automatic cyc3(input logic req, input logic fv, input logic [1:0] fidx,
                        input logic rst, input logic exp_fire, input logic [1:0] exp_idx);
        @(negedge clk);
        r3_req      = req;
        r3_free_vld = fv;
        r3_free_idx = fidx;
        r3_reset    = rst;
        #1;
        if (!rst) chk("r3.fire", {31'd0, r3_fire}, {31'd0, exp_fire});
        if (!rst && exp_fire) chk("r3.grant_idx", {30'd0, r3_idx}, {30'd0, exp_idx});
        @(posedge clk);
        #1;
        r3_req      = 1'b0;
        r3_free_vld = 1'b0;
        r3_reset    = 1'b0;
    endtask

    task automatic st3(input string tag, input logic [2:0] e_busy, input logic [1:0] e_cnt,
                       input logic e_full, input logic e_vld, input logic [1:0] e_idx);
        chk({tag, ".busy"},  {29'd0, r3_busy},  {29'd0, e_busy});
        chk({tag, ".count"}, {30'd0, r3_count}, {30'd0, e_cnt});
        chk({tag, ".full"},  {31'd0, r3_full},  {31'd0, e_full});
        chk({tag, ".vld"},   {31'd0, r3_vld},   {31'd0, e_vld});
        chk({tag, ".idx"},   {30'd0, r3_idx},   {30'd0, e_idx});
    endtask

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 0);
        st("reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0);

        // Fill in order, then a fifth request is refused
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2);
        st("t1_three", 4'b0111, 3'd3, 1'b0, 1'b0, 1'b1, 2'd3);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 3);
        st("t1_full", 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 0);
        st("t1_refused", 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0);

        // Free from full, re-grant the freed slot
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 0);
        st("t2_freed", 4'b1011, 3'd3, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2);
        st("t2_refull", 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0);

        // Drain to busy={3} with rr_ptr=3: search wraps to 0
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 0);
        st("t4_free1", 4'b1101, 3'd3, 1'b0, 1'b0, 1'b1, 2'd1);
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 0);
        st("t4_wrap", 4'b1000, 3'd1, 1'b0, 1'b0, 1'b1, 2'd0);

        // Build busy=1011, then reset with req and free pending
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0);
        st("t6_pre", 4'b1001, 3'd2, 1'b0, 1'b0, 1'b1, 2'd1);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1);
        st("t6_setup", 4'b1011, 3'd3, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 0);
        st("t6_reset", 4'b0000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0);

        // Simultaneous alloc and free: count holds, freed slot not re-offered
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 0);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1);
        st("t3_setup", 4'b0011, 3'd2, 1'b0, 1'b0, 1'b1, 2'd2);
        cyc(1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 2);
        st("t3_both", 4'b0101, 3'd2, 1'b0, 1'b0, 1'b1, 2'd3);

        // Release of a slot that is not busy changes nothing
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 0);
        st("t5_nonbusy", 4'b0101, 3'd2, 1'b0, 1'b0, 1'b1, 2'd3);

        // Fire at count==NUM_SLOTS-1 reaches full
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 3);
        st("t7_three", 4'b1101, 3'd3, 1'b0, 1'b0, 1'b1, 2'd1);
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1);
        st("t7_full", 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 2'd0);

        chk("scoreboard_drained", exp_q.size(), 0);

        // 3-slot instance: pointer wrap from 2 to 0 and out-of-range release
        cyc3(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0);
        st3("r3_reset", 3'b000, 2'd0, 1'b0, 1'b1, 2'd0);
        cyc3(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
        cyc3(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1);
        cyc3(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2);
        st3("r3_full", 3'b111, 2'd3, 1'b1, 1'b0, 2'd0);
        cyc3(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd0);
        st3("r3_oob_free", 3'b111, 2'd3, 1'b1, 1'b0, 2'd0);
        cyc3(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0);
        cyc3(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 2'd0);
        st3("r3_wrap", 3'b100, 2'd1, 1'b0, 1'b1, 2'd0);
        cyc3(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0);
        st3("r3_next", 3'b101, 2'd2, 1'b0, 1'b1, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
